// File: rtl/gpio_irq_pkg.sv
// Shared register map and synchroniser depth limits for the gpio_irq Wishbone slave.
package gpio_irq_pkg;
  localparam int GPIO_DIR     = 0;
  localparam int GPIO_OUT     = 1;
  localparam int GPIO_IN      = 2;
  localparam int GPIO_SET     = 3;
  localparam int GPIO_CLR     = 4;
  localparam int GPIO_TGL     = 5;
  localparam int GPIO_IRQ_EN  = 6;
  localparam int GPIO_RISE_EN = 7;
  localparam int GPIO_FALL_EN = 8;
  localparam int GPIO_STATUS  = 9;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-flop pin synchroniser plus one-cycle history; emits raw (unmasked) edge vectors.
module gpio_sync_edge
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  generate
    if (STAGES < SYNC_MIN || STAGES > SYNC_MAX) begin : g_bad_stages
      $error("gpio_sync_edge: STAGES out of range");
    end
  endgenerate

  // chain[0] takes the raw pin, chain[STAGES-1] is the settled value
  logic [STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]             prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/gpio_irq.sv
// Wishbone GPIO slave: direction/output latch with atomic set/clr/toggle and edge interrupts.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int Aw          = 4,
  parameter int SELw        = 4,
  parameter int TAGw        = 3,
  parameter int PORT_WIDTH  = 8,
  parameter int Dw          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [Dw-1:0]         sa_dat_i,
  input  logic [SELw-1:0]       sa_sel_i,
  input  logic [Aw-1:0]         sa_addr_i,
  input  logic [TAGw-1:0]       sa_tag_i,
  input  logic                  sa_stb_i,
  input  logic                  sa_cyc_i,
  input  logic                  sa_we_i,
  output logic [Dw-1:0]         sa_dat_o,
  output logic                  sa_ack_o,
  output logic                  sa_err_o,
  output logic                  sa_rty_o,
  input  logic [PORT_WIDTH-1:0] port_i,
  output logic [PORT_WIDTH-1:0] port_o,
  output logic [PORT_WIDTH-1:0] port_oe,
  output logic                  irq_o
);
  logic [PORT_WIDTH-1:0] dir_q, out_q, irq_en_q, rise_en_q, fall_en_q, status_q;
  logic [PORT_WIDTH-1:0] sync, rise, fall, wdat, w1c;
  logic [Dw-1:0]         rdata;
  logic                  access, wr;
  logic                  unused_ok;

  assign unused_ok = ^{sa_sel_i, sa_tag_i, sa_cyc_i, sa_dat_i};
  assign sa_err_o  = 1'b0;
  assign sa_rty_o  = 1'b0;
  assign port_o    = out_q;
  assign port_oe   = dir_q;

  // Masking with ack makes a held strobe act only once per transfer
  assign access = sa_stb_i & ~sa_ack_o;
  assign wr     = access & sa_we_i;
  assign wdat   = sa_dat_i[PORT_WIDTH-1:0];
  assign w1c    = (wr && sa_addr_i == Aw'(GPIO_STATUS)) ? wdat : '0;

  gpio_sync_edge #(.WIDTH(PORT_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (port_i),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    rdata = '0;
    case (sa_addr_i)
      Aw'(GPIO_DIR):     rdata[PORT_WIDTH-1:0] = dir_q;
      Aw'(GPIO_OUT):     rdata[PORT_WIDTH-1:0] = out_q;
      Aw'(GPIO_IN):      rdata[PORT_WIDTH-1:0] = sync;
      Aw'(GPIO_IRQ_EN):  rdata[PORT_WIDTH-1:0] = irq_en_q;
      Aw'(GPIO_RISE_EN): rdata[PORT_WIDTH-1:0] = rise_en_q;
      Aw'(GPIO_FALL_EN): rdata[PORT_WIDTH-1:0] = fall_en_q;
      Aw'(GPIO_STATUS):  rdata[PORT_WIDTH-1:0] = status_q;
      default:           rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q     <= '0;
      out_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      sa_ack_o  <= 1'b0;
      sa_dat_o  <= '0;
      irq_o     <= 1'b0;
    end else begin
      sa_ack_o <= access;
      if (access) sa_dat_o <= rdata;
      irq_o <= |(status_q & irq_en_q);
      // New edges are OR'd in after the W1C so a coincident edge is kept
      status_q <= (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
      if (wr) begin
        case (sa_addr_i)
          Aw'(GPIO_DIR):     dir_q     <= wdat;
          Aw'(GPIO_OUT):     out_q     <= wdat;
          Aw'(GPIO_SET):     out_q     <= out_q | wdat;
          Aw'(GPIO_CLR):     out_q     <= out_q & ~wdat;
          Aw'(GPIO_TGL):     out_q     <= out_q ^ wdat;
          Aw'(GPIO_IRQ_EN):  irq_en_q  <= wdat;
          Aw'(GPIO_RISE_EN): rise_en_q <= wdat;
          Aw'(GPIO_FALL_EN): fall_en_q <= wdat;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: cycle model with pin history, directed and random traffic.
module tb_gpio_irq;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic [3:0]  addr = '0;
  logic [2:0]  tag = '0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [31:0] dat_o;
  logic        ack, err, rty;
  logic [7:0]  pin = '0;
  logic [7:0]  pout, poe;
  logic        irq;

  int checks = 0;
  int passed = 0;

  gpio_irq #(.Aw(4), .SELw(4), .TAGw(3), .PORT_WIDTH(8), .Dw(32), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset),
    .sa_dat_i(dat), .sa_sel_i(sel), .sa_addr_i(addr), .sa_tag_i(tag),
    .sa_stb_i(stb), .sa_cyc_i(cyc), .sa_we_i(we),
    .sa_dat_o(dat_o), .sa_ack_o(ack), .sa_err_o(err), .sa_rty_o(rty),
    .port_i(pin), .port_o(pout), .port_oe(poe), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Register contents as a table indexed by address; pin history hist[k] = pin sampled k edges ago.
  logic [7:0]  m_reg [0:15];
  logic [7:0]  hist  [0:S];
  logic        m_irq = 1'b0, m_ack = 1'b0, m_rdv = 1'b0;
  logic [31:0] m_rd = '0;

  initial begin
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    for (int i = 0; i <= S; i++) hist[i] = '0;
  end

  wire        m_acc  = stb & ~m_ack;
  wire [7:0]  m_d    = dat[7:0];
  wire [7:0]  m_in   = hist[S-1];
  wire [7:0]  m_old  = hist[S];
  wire [7:0]  m_evt  = (m_in & ~m_old & m_reg[7]) | (~m_in & m_old & m_reg[8]);
  wire [7:0]  m_clr  = (m_acc && we && addr == 4'd9) ? m_d : 8'h00;
  wire [31:0] m_view = (addr == 4'd2) ? {24'h0, m_in} :
                       (addr inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9}) ? {24'h0, m_reg[addr]} : 32'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= '0;
      for (int i = 0; i <= S; i++) hist[i] <= '0;
      m_irq <= 1'b0; m_ack <= 1'b0; m_rdv <= 1'b0; m_rd <= '0;
    end else begin
      m_irq <= |(m_reg[9] & m_reg[6]);
      m_ack <= m_acc;
      m_rdv <= m_acc & ~we;
      if (m_acc) m_rd <= m_view;
      for (int i = 1; i <= S; i++) hist[i] <= hist[i-1];
      hist[0] <= pin;
      m_reg[9] <= (m_reg[9] & ~m_clr) | m_evt;
      if (m_acc && we) begin
        case (addr)
          4'd0, 4'd1, 4'd6, 4'd7, 4'd8: m_reg[addr] <= m_d;
          4'd3: m_reg[1] <= m_reg[1] | m_d;
          4'd4: m_reg[1] <= m_reg[1] & ~m_d;
          4'd5: m_reg[1] <= m_reg[1] ^ m_d;
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("port_o",  {24'h0, pout}, {24'h0, m_reg[1]});
      chk("port_oe", {24'h0, poe},  {24'h0, m_reg[0]});
      chk("irq_o",   {31'h0, irq},  {31'h0, m_irq});
      chk("ack",     {31'h0, ack},  {31'h0, m_ack});
      chk("err_rty", {30'h0, err, rty}, 32'h0);
      if (m_rdv) chk("rd_data", dat_o, m_rd);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                     input bit hold, output logic [31:0] q);
    int n;
    stb = 1'b1; cyc = 1'b1; we = w; addr = a; dat = d; n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 8);
    if (!ack) chk("ack_timeout", {31'h0, ack}, 32'h1);
    q = dat_o;
    if (hold) begin @(posedge clk); #1; end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, d, 1'b0, q);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] q);
    bus(1'b0, a, 32'h0, 1'b0, q);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] q;
    #1 reset = 1'b0;
    cyc_wait(3);
    reset = 1'b1;
    cyc_wait(1);

    // Reset state
    for (int a = 0; a < 10; a++) begin
      rd(4'(a), q);
      chk($sformatf("reset_rd%0d", a), q, 32'h0);
    end
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_oe", {24'h0, poe}, 32'h0);

    // Output latch and atomic ops; TGL strobe held an extra cycle
    wr(4'd0, 32'hF0);
    wr(4'd1, 32'hA5);
    wr(4'd3, 32'h0A);
    wr(4'd4, 32'h80);
    bus(1'b1, 4'd5, 32'h03, 1'b1, q);
    cyc_wait(1);
    chk("port_o_lit", {24'h0, pout}, 32'h2C);
    chk("port_oe_lit", {24'h0, poe}, 32'hF0);
    rd(4'd1, q);
    chk("out_rd_lit", q, 32'h2C);

    // Rising edge on bit 0: STATUS after S+1 edges, irq one later
    wr(4'd7, 32'h01);
    wr(4'd6, 32'h01);
    pin[0] = 1'b1;
    for (int k = 1; k <= S + 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rise_irq_c%0d", k), {31'h0, irq}, (k == S + 2) ? 32'h1 : 32'h0);
    end
    rd(4'd9, q);
    chk("status_rise_lit", q, 32'h01);
    wr(4'd9, 32'h01);
    cyc_wait(1);
    chk("w1c_irq_lit", {31'h0, irq}, 32'h0);
    rd(4'd9, q);
    chk("status_w1c_lit", q, 32'h00);

    // Falling edge on bit 1 with the interrupt masked
    wr(4'd8, 32'h02);
    wr(4'd6, 32'h00);
    pin[1] = 1'b1; cyc_wait(6);
    pin[1] = 1'b0; cyc_wait(6);
    rd(4'd9, q);
    chk("status_fall_lit", q, 32'h02);
    chk("masked_irq_lit", {31'h0, irq}, 32'h0);
    wr(4'd6, 32'h02);
    cyc_wait(1);
    chk("unmask_irq_lit", {31'h0, irq}, 32'h1);

    // Edge coinciding with W1C on the same bit: edge wins
    wr(4'd6, 32'h03);
    pin[0] = 1'b0; cyc_wait(6);
    pin[0] = 1'b1;
    cyc_wait(S);
    wr(4'd9, 32'h01);
    rd(4'd9, q);
    chk("coincide_status_lit", q, 32'h03);
    chk("coincide_irq_lit", {31'h0, irq}, 32'h1);

    // Random traffic against the model
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin pin = 8'($urandom); cyc_wait($urandom_range(1, 4)); end
        3, 4, 5: bus(1'b1, 4'($urandom_range(0, 15)), $urandom, bit'($urandom_range(0, 1)), q);
        6, 7:    rd(4'($urandom_range(0, 15)), q);
        default: cyc_wait($urandom_range(1, 3));
      endcase
    end

    // Reset in the middle of a write
    stb = 1'b1; cyc = 1'b1; we = 1'b1; addr = 4'd0; dat = 32'h55;
    reset = 1'b0;
    cyc_wait(2);
    chk("rst_mid_ack", {31'h0, ack}, 32'h0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    reset = 1'b1;
    pin = '0;
    cyc_wait(1);
    rd(4'd0, q);
    chk("rst_mid_dir", q, 32'h0);
    rd(4'd1, q);
    chk("rst_mid_out", q, 32'h0);
    wr(4'd0, 32'h3C);
    rd(4'd0, q);
    chk("post_rst_dir", q, 32'h3C);

    cyc_wait(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
